// File: rtl/ps2_rx_regs.sv
// PS/2 keyboard receiver with an 8-bit CPU register file.
// Scan codes are collected by a small receive FSM, stored in a FIFO, and read
// back through a registered read bus. irq stays high while data is pending and
// the interrupt is enabled.
module ps2_rx_regs #(
    parameter int N       = 13,
    parameter int M       = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sncs,
    input  logic         snwe,
    input  logic [N-1:0] buffer_addr,
    input  logic [M-1:0] buffer_data,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    output logic [M-1:0] rdBus,
    output logic         irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // PS/2 line synchronisers (idle level of both lines is high)
    logic ps2c_s1_q, ps2c_s1_d;
    logic ps2c_s2_q, ps2c_s2_d;
    logic ps2c_prev_q, ps2c_prev_d;
    logic ps2d_s1_q, ps2d_s1_d;
    logic ps2d_s2_q, ps2d_s2_d;
    logic fall;
    logic rx_bit;

    // Receive FSM
    state_t        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tocnt_q, tocnt_d;
    logic          rx_push;
    logic          rx_err;

    // Bus interface tracking
    logic snwe_prev_q, snwe_prev_d;
    logic sncs_prev_q, sncs_prev_d;
    logic acc_wr_q, acc_wr_d;
    logic last_addr0_q, last_addr0_d;
    logic wr_stb;
    logic cs_rise;
    logic pop_req;
    logic wr_ctrl;
    logic flush;
    logic clr;

    // Registers and FIFO
    logic          irq_en_q, irq_en_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          nempty;
    logic          do_push;
    logic          do_pop;
    logic          ovf_set;

    // Read path and interrupt
    logic [7:0]   rd_byte;
    logic [M-1:0] rdbus_q, rdbus_d;
    logic         irq_q, irq_d;

    // Only the low address bits and low control bits carry meaning.
    logic unused_bits;
    assign unused_bits = ^{buffer_addr[N-1:2], buffer_data[M-1:3]};

    // Next values of the two-flop synchronisers and the edge history flop
    always_comb begin
        ps2c_s1_d   = ps2_clk;
        ps2c_s2_d   = ps2c_s1_q;
        ps2c_prev_d = ps2c_s2_q;
        ps2d_s1_d   = ps2_data;
        ps2d_s2_d   = ps2d_s1_q;
    end

    assign fall   = ps2c_prev_q & ~ps2c_s2_q;
    assign rx_bit = ps2d_s2_q;

    // Receive FSM next-state: frame sequencing, bit shifting and timeout count
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tocnt_d  = '0;
        if (state_q == S_IDLE) begin
            if (fall && !rx_bit) begin
                state_d  = S_DATA;
                bitcnt_d = 3'd0;
            end
        end else if (fall) begin
            case (state_q)
                S_DATA: begin
                    shift_d  = {rx_bit, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    parity_d = rx_bit;
                    state_d  = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if (tocnt_q == TW'(TIMEOUT)) begin
            state_d = S_IDLE;
        end else begin
            tocnt_d = tocnt_q + 1'b1;
        end
    end

    // Receive FSM outputs: accept a finished byte or flag a framing error
    always_comb begin
        rx_push = 1'b0;
        rx_err  = 1'b0;
        if (state_q != S_IDLE) begin
            if (fall) begin
                if (state_q == S_STOP) begin
                    if (rx_bit && (^{shift_q, parity_q})) begin
                        rx_push = 1'b1;
                    end else begin
                        rx_err = 1'b1;
                    end
                end
            end else if (tocnt_q == TW'(TIMEOUT)) begin
                rx_err = 1'b1;
            end
        end
    end

    assign wr_stb  = ~snwe_prev_q & snwe & ~sncs;
    assign cs_rise = ~sncs_prev_q & sncs;
    // A data read is judged on the address seen on the final selected cycle.
    assign pop_req = cs_rise & last_addr0_q & ~acc_wr_q;
    assign wr_ctrl = wr_stb & (buffer_addr[1:0] == 2'd2);
    assign flush   = wr_ctrl & buffer_data[2];
    assign clr     = wr_ctrl & buffer_data[1];

    // Bus cycle tracking: strobe edges, write-in-cycle flag, last address
    always_comb begin
        snwe_prev_d = snwe;
        sncs_prev_d = sncs;
        if (!sncs) begin
            acc_wr_d     = acc_wr_q | wr_stb;
            last_addr0_d = (buffer_addr[1:0] == 2'd0);
        end else begin
            acc_wr_d     = 1'b0;
            last_addr0_d = 1'b0;
        end
    end

    assign full    = (count_q == CW'(DEPTH));
    assign nempty  = (count_q != '0);
    assign do_pop  = pop_req & nempty;
    // A full FIFO still accepts a byte when a pop frees a slot the same cycle.
    assign do_push = rx_push & (~full | do_pop);
    assign ovf_set = rx_push & full & ~do_pop;

    // FIFO and control register updates; flush overrides push and pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        irq_en_d = wr_ctrl ? buffer_data[0] : irq_en_q;
        ovf_d    = (ovf_q & ~clr) | (ovf_set & ~flush);
        err_d    = (err_q & ~clr) | rx_err;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = shift_q;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Register read mux and interrupt level
    always_comb begin
        case (buffer_addr[1:0])
            2'd0:    rd_byte = nempty ? mem_q[rd_ptr_q] : 8'h00;
            2'd1:    rd_byte = {3'b000, irq_en_q, err_q, ovf_q, full, nempty};
            2'd2:    rd_byte = {7'b0000000, irq_en_q};
            default: rd_byte = 8'(count_q);
        endcase
        rdbus_d = M'(rd_byte);
        irq_d   = irq_en_q & nempty;
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2c_s1_q    <= 1'b1;
            ps2c_s2_q    <= 1'b1;
            ps2c_prev_q  <= 1'b1;
            ps2d_s1_q    <= 1'b1;
            ps2d_s2_q    <= 1'b1;
            state_q      <= S_IDLE;
            bitcnt_q     <= 3'd0;
            tocnt_q      <= '0;
            snwe_prev_q  <= 1'b1;
            sncs_prev_q  <= 1'b1;
            acc_wr_q     <= 1'b0;
            last_addr0_q <= 1'b0;
            irq_en_q     <= 1'b0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rdbus_q      <= '0;
            irq_q        <= 1'b0;
        end else begin
            ps2c_s1_q    <= ps2c_s1_d;
            ps2c_s2_q    <= ps2c_s2_d;
            ps2c_prev_q  <= ps2c_prev_d;
            ps2d_s1_q    <= ps2d_s1_d;
            ps2d_s2_q    <= ps2d_s2_d;
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            tocnt_q      <= tocnt_d;
            snwe_prev_q  <= snwe_prev_d;
            sncs_prev_q  <= sncs_prev_d;
            acc_wr_q     <= acc_wr_d;
            last_addr0_q <= last_addr0_d;
            irq_en_q     <= irq_en_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rdbus_q      <= rdbus_d;
            irq_q        <= irq_d;
        end
    end

    // Datapath storage: shift register, parity and FIFO contents, no reset
    always_ff @(posedge clk) begin
        shift_q  <= shift_d;
        parity_q <= parity_d;
        mem_q    <= mem_d;
    end

    assign rdBus = rdbus_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_ps2_rx_regs.sv
// Testbench for ps2_rx_regs: drives PS/2 frames and bus cycles, keeps a
// reference FIFO queue of expected bytes and compares every register read.
module tb_ps2_rx_regs;

    localparam int N     = 13;
    localparam int M     = 8;
    localparam int DEPTH = 16;
    localparam int TMO   = 400;
    localparam int H     = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         sncs;
    logic         snwe;
    logic [N-1:0] buffer_addr;
    logic [M-1:0] buffer_data;
    logic         ps2_clk;
    logic         ps2_data;
    logic [M-1:0] rdBus;
    logic         irq;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];
    logic       mdl_irq_en;
    logic       mdl_ovf;
    logic       mdl_err;

    ps2_rx_regs #(.N(N), .M(M), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .sncs        (sncs),
        .snwe        (snwe),
        .buffer_addr (buffer_addr),
        .buffer_data (buffer_data),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rdBus       (rdBus),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mdl_status();
        return {3'b000, mdl_irq_en, mdl_err, mdl_ovf,
                exp_q.size() == DEPTH, exp_q.size() != 0};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_push(input logic [7:0] d);
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else mdl_ovf = 1'b1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        idle(H);
        ps2_clk = 1'b0;
        idle(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        logic p;
        p = (~^d) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(p);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        idle(H);
        if (bad_par) mdl_err = 1'b1;
        else model_push(d);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        sncs        = 1'b0;
        snwe        = 1'b1;
        buffer_addr = N'(a);
        idle(2);
        d    = rdBus;
        sncs = 1'b1;
        idle(2);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        sncs        = 1'b0;
        snwe        = 1'b0;
        buffer_addr = N'(a);
        buffer_data = d;
        idle(1);
        snwe = 1'b1;
        idle(1);
        sncs = 1'b1;
        idle(2);
        if (a == 2'd2) begin
            mdl_irq_en = d[0];
            if (d[1]) begin
                mdl_ovf = 1'b0;
                mdl_err = 1'b0;
            end
            if (d[2]) exp_q.delete();
        end
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        chk(tag, d, exp);
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] d;
        logic [7:0] e;
        e = 8'h00;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        bus_read(2'd0, d);
        chk(tag, d, e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] e;
        logic       p;

        reset       = 1'b1;
        sncs        = 1'b1;
        snwe        = 1'b1;
        buffer_addr = '0;
        buffer_data = '0;
        ps2_clk     = 1'b1;
        ps2_data    = 1'b1;
        mdl_irq_en  = 1'b0;
        mdl_ovf     = 1'b0;
        mdl_err     = 1'b0;
        idle(4);
        reset = 1'b0;
        idle(2);

        // reset state
        chk("rst_rdbus", rdBus, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        rd_chk("rst_status", 2'd1, 8'h00);
        rd_chk("rst_count", 2'd3, 8'h00);

        // single good frame, interrupt enable
        send_frame(8'h1C, 1'b0);
        rd_chk("t1_count", 2'd3, 8'h01);
        bus_write(2'd2, 8'h01);
        idle(2);
        chk("t1_irq_on", {7'b0, irq}, 8'h01);
        rd_chk("t1_status", 2'd1, 8'h11);
        rd_chk("t1_ctrl", 2'd2, 8'h01);
        pop_chk("t1_data");
        idle(2);
        chk("t1_irq_off", {7'b0, irq}, 8'h00);
        bus_write(2'd2, 8'h00);

        // bad parity, then clear
        send_frame(8'h1C, 1'b1);
        rd_chk("t2_count", 2'd3, 8'h00);
        rd_chk("t2_status_err", 2'd1, 8'h08);
        bus_write(2'd2, 8'h02);
        rd_chk("t2_status_clr", 2'd1, 8'h00);

        // overflow with 17 frames, then drain in order
        for (int i = 0; i < 17; i++) send_frame(8'(8'h30 + i * 7), 1'b0);
        rd_chk("t3_count_full", 2'd3, 8'h10);
        rd_chk("t3_status_full", 2'd1, 8'h07);
        for (int i = 0; i < 16; i++) pop_chk("t3_data");
        rd_chk("t3_count_empty", 2'd3, 8'h00);
        rd_chk("t3_status_ovf", 2'd1, mdl_status());
        bus_write(2'd2, 8'h02);

        // partial frame aborted by timeout
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        idle(TMO + 20);
        mdl_err = 1'b1;
        rd_chk("t4_status_err", 2'd1, 8'h08);
        rd_chk("t4_count", 2'd3, 8'h00);
        bus_write(2'd2, 8'h02);
        send_frame(8'hF0, 1'b0);
        pop_chk("t4_data_f0");
        rd_chk("t4_count_after", 2'd3, 8'h00);

        // full FIFO, stop-bit push coincides with the pop at sncs rise
        for (int i = 0; i < 16; i++) send_frame(8'(8'hA0 + i), 1'b0);
        rd_chk("t5_count_full", 2'd3, 8'h10);
        rd_chk("t5_status_full", 2'd1, 8'h03);
        p = ~^8'h55;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            e = 8'h55;
            ps2_bit(e[i]);
        end
        ps2_bit(p);
        ps2_data    = 1'b1;
        sncs        = 1'b0;
        snwe        = 1'b1;
        buffer_addr = '0;
        idle(H);
        ps2_clk = 1'b0;
        idle(2);
        d    = rdBus;
        sncs = 1'b1;
        e    = exp_q.pop_front();
        chk("t5_read_head", d, e);
        model_push(8'h55);
        idle(H - 2);
        ps2_clk = 1'b1;
        idle(H);
        rd_chk("t5_count_same", 2'd3, 8'h10);
        rd_chk("t5_status_no_ovf", 2'd1, 8'h03);
        for (int i = 0; i < 16; i++) pop_chk("t5_data");

        // reset in the middle of a frame with data pending
        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        send_frame(8'h33, 1'b0);
        bus_write(2'd2, 8'h01);
        idle(2);
        chk("t6_irq_before", {7'b0, irq}, 8'h01);
        rd_chk("t6_count_before", 2'd3, 8'h03);
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'(i & 1));
        ps2_data = 1'b0;
        idle(H / 2);
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        exp_q.delete();
        mdl_irq_en = 1'b0;
        mdl_ovf    = 1'b0;
        mdl_err    = 1'b0;
        chk("t6_rdbus_rst", rdBus, 8'h00);
        chk("t6_irq_rst", {7'b0, irq}, 8'h00);
        ps2_data = 1'b1;
        idle(2 * H);
        rd_chk("t6_count_rst", 2'd3, 8'h00);
        send_frame(8'h5A, 1'b0);
        pop_chk("t6_data_5a");
        pop_chk("t6_empty_read");
        rd_chk("t6_count_end", 2'd3, 8'h00);

        // flush
        send_frame(8'h77, 1'b0);
        send_frame(8'h88, 1'b0);
        rd_chk("t7_count_two", 2'd3, 8'h02);
        bus_write(2'd2, 8'h04);
        rd_chk("t7_count_flush", 2'd3, 8'h00);
        rd_chk("t7_status_flush", 2'd1, mdl_status());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
